// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: 3-stage pipelined adder/subtractor with valid/ready.
// Uses 4-bit lookahead groups and a second lookahead level across groups.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             gp,
  output logic             gg
);
  localparam int NG = WIDTH / 4;
  localparam int NB = (NG + 3) / 4;

  // Flat sum-of-products carry into position k of a 4-wide lookahead cell.
  function automatic logic la(input logic [3:0] p, input logic [3:0] g, input logic ci, input int k);
    logic t;
    la = 1'b0;
    for (int i = 0; i <= k; i++) begin
      t = (i == 0) ? ci : g[i-1];
      for (int j = 0; j < 4; j++) t = (j >= i && j < k) ? t & p[j] : t;
      la = la | t;
    end
  endfunction

  logic [WIDTH-1:0] b_d;
  logic             s1_v_q, s1_c0_q;
  logic [WIDTH-1:0] s1_p_q, s1_g_q;
  logic [4*NB-1:0]  grp_p_d, grp_g_d;
  logic [3:0]       blk_p_d, blk_g_d;
  logic [NB:0]      blk_c_d;
  logic [NG:0]      grp_c_d;
  logic [WIDTH:0]   c_d;
  logic             gp_d, gg_d;
  logic             s2_v_q, s2_gp_q, s2_gg_q;
  logic [WIDTH-1:0] s2_p_q;
  logic [WIDTH:0]   s2_c_q;
  logic             out_valid_q, cout_q, ovf_q, gp_q, gg_q;
  logic [WIDTH-1:0] sum_q;

  assign in_ready = ~(out_valid_q & ~out_ready);
  assign b_d      = sub ? ~b : b;

  always_ff @(posedge clk) begin
    if (rst) s1_v_q <= 1'b0;
    else if (in_ready) s1_v_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_ready) begin
      s1_p_q  <= a ^ b_d;
      s1_g_q  <= a & b_d;
      s1_c0_q <= sub | cin;
    end
  end

  // Unused high groups/blocks are padded with P=1, G=0 so they pass carries through.
  always_comb begin
    grp_p_d = '1;
    grp_g_d = '0;
    for (int j = 0; j < NG; j++) begin
      grp_p_d[j] = &s1_p_q[4*j +: 4];
      grp_g_d[j] = la(s1_p_q[4*j +: 4], s1_g_q[4*j +: 4], 1'b0, 4);
    end
    blk_p_d = '1;
    blk_g_d = '0;
    for (int k = 0; k < NB; k++) begin
      blk_p_d[k] = &grp_p_d[4*k +: 4];
      blk_g_d[k] = la(grp_p_d[4*k +: 4], grp_g_d[4*k +: 4], 1'b0, 4);
    end
    for (int k = 0; k <= NB; k++) blk_c_d[k] = la(blk_p_d, blk_g_d, s1_c0_q, k);
    gp_d = &blk_p_d;
    gg_d = la(blk_p_d, blk_g_d, 1'b0, 4);
    grp_c_d = '0;
    for (int j = 0; j < NG; j++)
      grp_c_d[j] = la(grp_p_d[4*(j/4) +: 4], grp_g_d[4*(j/4) +: 4], blk_c_d[j/4], j % 4);
    grp_c_d[NG] = blk_c_d[NB];
    c_d = '0;
    for (int i = 0; i < WIDTH; i++)
      c_d[i] = la(s1_p_q[4*(i/4) +: 4], s1_g_q[4*(i/4) +: 4], grp_c_d[i/4], i % 4);
    c_d[WIDTH] = grp_c_d[NG];
  end

  always_ff @(posedge clk) begin
    if (rst) s2_v_q <= 1'b0;
    else if (in_ready) s2_v_q <= s1_v_q;
  end

  always_ff @(posedge clk) begin
    if (in_ready) begin
      s2_p_q  <= s1_p_q;
      s2_c_q  <= c_d;
      s2_gp_q <= gp_d;
      s2_gg_q <= gg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      gp_q        <= 1'b0;
      gg_q        <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= s2_v_q;
      sum_q       <= s2_p_q ^ s2_c_q[WIDTH-1:0];
      cout_q      <= s2_c_q[WIDTH];
      ovf_q       <= s2_c_q[WIDTH] ^ s2_c_q[WIDTH-1];
      gp_q        <= s2_gp_q;
      gg_q        <= s2_gg_q;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign gp        = gp_q;
  assign gg        = gg_q;
endmodule
